// File: rtl/execute_pipe_reg.sv
// rtl/execute_pipe_reg.sv - Y86-64 decode-to-execute pipeline register with condition-code register.
module execute_pipe_reg #(
  parameter logic [2:0] STAT_AOK  = 3'd1,
  parameter logic [2:0] STAT_HLT  = 3'd2,
  parameter logic [2:0] STAT_ADR  = 3'd3,
  parameter logic [2:0] STAT_INS  = 3'd4,
  parameter logic [3:0] RNONE     = 4'hF,
  parameter logic [3:0] NOP_ICODE = 4'h1,
  parameter logic [2:0] CC_RESET  = 3'b100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  D_stat,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [63:0] D_valC,
  input  logic [63:0] d_valA,
  input  logic [63:0] d_valB,
  input  logic [3:0]  d_dstE,
  input  logic [3:0]  d_dstM,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic        E_stall,
  input  logic        E_bubble,
  input  logic [2:0]  cf,
  input  logic [2:0]  m_stat,
  input  logic [2:0]  W_stat,
  output logic [2:0]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB,
  output logic [2:0]  outf,
  output logic        set_cc,
  output logic        ctl_err
);

  localparam logic [3:0] OPQ_ICODE = 4'h6;

  logic [2:0]  r_stat;
  logic [3:0]  r_icode;
  logic [3:0]  r_ifun;
  logic [63:0] r_valC;
  logic [63:0] r_valA;
  logic [63:0] r_valB;
  logic [3:0]  r_dstE;
  logic [3:0]  r_dstM;
  logic [3:0]  r_srcA;
  logic [3:0]  r_srcB;
  logic [2:0]  r_outf;
  logic        r_ctl_err;

  logic        w_m_exc;
  logic        w_W_exc;
  logic        w_set_cc;

  // Stall takes precedence over bubble; reset discards everything.
  always_ff @(posedge clk) begin
    if (reset || (E_bubble && !E_stall)) begin
      r_stat  <= STAT_AOK;
      r_icode <= NOP_ICODE;
      r_ifun  <= 4'h0;
      r_valC  <= 64'd0;
      r_valA  <= 64'd0;
      r_valB  <= 64'd0;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
      r_srcA  <= RNONE;
      r_srcB  <= RNONE;
    end else if (!E_stall) begin
      r_stat  <= D_stat;
      r_icode <= D_icode;
      r_ifun  <= D_ifun;
      r_valC  <= D_valC;
      r_valA  <= d_valA;
      r_valB  <= d_valB;
      r_dstE  <= d_dstE;
      r_dstM  <= d_dstM;
      r_srcA  <= d_srcA;
      r_srcB  <= d_srcB;
    end
  end

  // Flags follow the instruction already in E, regardless of stall/bubble.
  assign w_m_exc  = (m_stat == STAT_ADR) || (m_stat == STAT_INS) || (m_stat == STAT_HLT);
  assign w_W_exc  = (W_stat == STAT_ADR) || (W_stat == STAT_INS) || (W_stat == STAT_HLT);
  assign w_set_cc = (r_icode == OPQ_ICODE) && !w_m_exc && !w_W_exc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_outf    <= CC_RESET;
      r_ctl_err <= 1'b0;
    end else begin
      if (w_set_cc) begin
        r_outf <= cf;
      end
      r_ctl_err <= E_stall && E_bubble;
    end
  end

  assign E_stat  = r_stat;
  assign E_icode = r_icode;
  assign E_ifun  = r_ifun;
  assign E_valC  = r_valC;
  assign E_valA  = r_valA;
  assign E_valB  = r_valB;
  assign E_dstE  = r_dstE;
  assign E_dstM  = r_dstM;
  assign E_srcA  = r_srcA;
  assign E_srcB  = r_srcB;
  assign outf    = r_outf;
  assign set_cc  = w_set_cc;
  assign ctl_err = r_ctl_err;

endmodule

// File: tb/tb_execute_pipe_reg.sv
// tb/tb_execute_pipe_reg.sv - directed self-checking bench for execute_pipe_reg.
module tb_execute_pipe_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun;
  logic [63:0] D_valC, d_valA, d_valB;
  logic [3:0]  d_dstE, d_dstM, d_srcA, d_srcB;
  logic        E_stall, E_bubble;
  logic [2:0]  cf, m_stat, W_stat;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;
  logic [2:0]  outf;
  logic        set_cc, ctl_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_pipe_reg dut (
    .clk(clk), .reset(reset),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_valC(D_valC),
    .d_valA(d_valA), .d_valB(d_valB),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stall(E_stall), .E_bubble(E_bubble), .cf(cf),
    .m_stat(m_stat), .W_stat(W_stat),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .outf(outf), .set_cc(set_cc), .ctl_err(ctl_err)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] valc,
                         input logic [63:0] vala, input logic [63:0] valb, input logic [3:0] dste);
    D_stat  = 3'd1;
    D_icode = icode;
    D_ifun  = ifun;
    D_valC  = valc;
    d_valA  = vala;
    d_valB  = valb;
    d_dstE  = dste;
    d_dstM  = 4'hF;
    d_srcA  = 4'h2;
    d_srcB  = 4'h3;
  endtask

  initial begin
    reset = 1'b1; E_stall = 1'b0; E_bubble = 1'b0;
    m_stat = 3'd1; W_stat = 3'd1; cf = 3'b011;
    D_stat = 3'($urandom); D_icode = 4'($urandom); D_ifun = 4'($urandom);
    D_valC = {$urandom, $urandom}; d_valA = {$urandom, $urandom}; d_valB = {$urandom, $urandom};
    d_dstE = 4'($urandom); d_dstM = 4'($urandom); d_srcA = 4'($urandom); d_srcB = 4'($urandom);
    step();
    check("rst_icode", E_icode, 1);
    check("rst_stat", E_stat, 1);
    check("rst_ifun", E_ifun, 0);
    check("rst_ids", {E_dstE, E_dstM, E_srcA, E_srcB}, 16'hFFFF);
    check("rst_vals", E_valC | E_valA | E_valB, 0);
    check("rst_outf", outf, 3'b100);
    check("rst_ctl_err", ctl_err, 0);
    check("rst_set_cc", set_cc, 0);

    // OPq subq: 50-30 gives ZF=SF=OF=0
    reset = 1'b0;
    drive_d(4'h6, 4'h1, 64'd0, 64'd30, 64'd50, 4'h3);
    cf = 3'b000;
    step();
    check("load_icode", E_icode, 6);
    check("load_ifun", E_ifun, 1);
    check("load_valA", E_valA, 30);
    check("load_valB", E_valB, 50);
    check("load_dstE", E_dstE, 3);
    check("load_srcs", {E_srcA, E_srcB}, 8'h23);
    check("load_set_cc", set_cc, 1);
    check("load_outf_pre", outf, 3'b100);
    drive_d(4'h6, 4'h1, 64'd0, 64'd50, 64'd50, 4'h3);
    step();
    check("opq_outf", outf, 3'b000);
    check("opq2_valA", E_valA, 50);

    // ZF result blocked while memory stage has an address error
    cf = 3'b100;
    m_stat = 3'd3;
    #1;
    check("gate_set_cc_m", set_cc, 0);
    step();
    check("gate_outf_hold", outf, 3'b000);
    m_stat = 3'd1;
    W_stat = 3'd4;
    #1;
    check("gate_set_cc_w", set_cc, 0);
    W_stat = 3'd1;
    #1;
    check("gate_set_cc_ok", set_cc, 1);
    step();
    check("gate_outf_upd", outf, 3'b100);

    // stall then bubble
    drive_d(4'h3, 4'h0, 64'd20, 64'd0, 64'd0, 4'h5);
    step();
    check("ld3_icode", E_icode, 3);
    check("ld3_valC", E_valC, 20);
    check("ld3_outf", outf, 3'b100);
    E_stall = 1'b1;
    drive_d(4'h7, 4'h2, 64'd99, 64'd1, 64'd2, 4'h6);
    step();
    check("stall1_icode", E_icode, 3);
    check("stall1_valC", E_valC, 20);
    drive_d(4'h8, 4'h0, 64'd77, 64'd3, 64'd4, 4'h7);
    step();
    check("stall2_icode", E_icode, 3);
    check("stall2_valC", E_valC, 20);
    check("stall2_dstE", E_dstE, 5);
    E_stall = 1'b0;
    E_bubble = 1'b1;
    step();
    check("bub_icode", E_icode, 1);
    check("bub_ids", {E_dstE, E_dstM, E_srcA, E_srcB}, 16'hFFFF);
    check("bub_valC", E_valC, 0);
    check("bub_ctl_err", ctl_err, 0);

    // stall and bubble together
    E_bubble = 1'b0;
    drive_d(4'h2, 4'h0, 64'd7, 64'd8, 64'd9, 4'h4);
    step();
    check("ld2_icode", E_icode, 2);
    E_stall = 1'b1;
    E_bubble = 1'b1;
    drive_d(4'h5, 4'h0, 64'd11, 64'd12, 64'd13, 4'h1);
    step();
    check("conf_icode", E_icode, 2);
    check("conf_valC", E_valC, 7);
    check("conf_ctl_err", ctl_err, 1);
    E_stall = 1'b0;
    E_bubble = 1'b0;
    step();
    check("conf_ctl_err_clr", ctl_err, 0);
    check("conf_load_icode", E_icode, 5);

    // reset mid-stream with OPq in E
    drive_d(4'h6, 4'h0, 64'd0, 64'd5, 64'd6, 4'h2);
    cf = 3'b001;
    step();
    check("mid_set_cc", set_cc, 1);
    cf = 3'b010;
    step();
    check("mid_outf", outf, 3'b010);
    cf = 3'b001;
    reset = 1'b1;
    step();
    check("mid_rst_outf", outf, 3'b100);
    check("mid_rst_icode", E_icode, 1);
    check("mid_rst_valA", E_valA, 0);
    check("mid_rst_dstE", E_dstE, 4'hF);
    check("mid_rst_set_cc", set_cc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_pipe_reg.md
# execute_pipe_reg

Pipeline register between the decode and execute stages of the pipelined Y86-64 processor, plus the architectural condition-code register. It captures the decode-stage instruction fields and operands each cycle and drives them to the execute-stage ALU operand, function and condition logic. It honours stall and bubble controls from the hazard unit. It also latches the ALU flags `cf` into `outf` when an OPq instruction may legally update them.

## Interface
Parameters:
- `STAT_AOK`, 3'd1, status code for normal operation; `STAT_HLT` 3'd2, `STAT_ADR` 3'd3, `STAT_INS` 3'd4.
- `RNONE`, 4'hF, register ID meaning "no register".
- `NOP_ICODE`, 4'h1, icode inserted as a bubble.
- `CC_RESET`, 3'b100, reset value of `outf` {ZF,SF,OF}.

Ports (single clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous active-high reset.
- `D_stat`  in  3  decode-stage status.
- `D_icode`, `D_ifun`  in  4 each  decode-stage instruction code and function.
- `D_valC`  in  64  decode-stage constant.
- `d_valA`, `d_valB`  in  64 each  forwarded operands from decode.
- `d_dstE`, `d_dstM`, `d_srcA`, `d_srcB`  in  4 each  register IDs.
- `E_stall`  in  1  hold the current contents.
- `E_bubble`  in  1  load a nop.
- `cf`  in  3  flags from the ALU for the instruction currently held in E.
- `m_stat`, `W_stat`  in  3 each  status of the instructions in memory and writeback.
- `E_stat`  out  3; `E_icode`, `E_ifun` out 4; `E_valC`, `E_valA`, `E_valB` out 64; `E_dstE`, `E_dstM`, `E_srcA`, `E_srcB` out 4.
- `outf`  out  3  condition codes {ZF,SF,OF}, registered.
- `set_cc`  out  1  combinational; flags latch on the next edge.
- `ctl_err`  out  1  registered; pulses when `E_stall` and `E_bubble` are both high.

## Operation
- Reset (`reset`=1 at edge): E loads the bubble value. Bubble value: `E_stat`=STAT_AOK, `E_icode`=4'h1, `E_ifun`=0, `E_valC`/`E_valA`/`E_valB`=0, all four register IDs=4'hF. Also `outf`=3'b100 and `ctl_err`=0. Reset overrides stall and bubble.
- Priority at each edge is reset > stall > bubble > load.
  - Stall: all E fields hold.
  - Bubble: E loads the bubble value.
  - Load: E captures `D_stat`, `D_icode`, `D_ifun`, `D_valC`, `d_valA`, `d_valB`, `d_dstE`, `d_dstM`, `d_srcA`, `d_srcB` unchanged.
- `E_stall` and `E_bubble` both high: the stall wins and E holds. `ctl_err`=1 for the following cycle only.
- `set_cc` = (`E_icode`==4'h6) AND `m_stat` not in {ADR,INS,HLT} AND `W_stat` not in {ADR,INS,HLT}.
- CC update: when `set_cc`=1 at an edge, `outf` takes `cf`; otherwise it holds.
  - The update is independent of `E_stall`/`E_bubble`. It follows the instruction currently in E, not the incoming one.
  - During a reset cycle `outf` takes CC_RESET regardless of `set_cc`.
- Fields are passed through unchanged. No ALU operations, no width changes, no sign extension.

## Timing
- Latency is one cycle: D-side inputs at edge n appear on E outputs after edge n.
- `cf` is produced combinationally from E outputs, so `outf` reflects an OPq one cycle after that OPq enters E. A conditional instruction in E on the next cycle sees the updated flags.
- Back-to-back OPq instructions update `outf` on consecutive edges.
- A stalled OPq with `set_cc`=1 rewrites the same flags every cycle it is held. This is harmless and required.
- Reset in mid-stream discards the E contents at that edge. No partial state survives.
- `set_cc` is combinational from registered E state and from `m_stat`/`W_stat`; it has no path from D-side inputs.

## Test plan
- Reset: hold `reset` 1 cycle with random D inputs. Required: E_icode=1, E_stat=1, IDs=F, vals=0, outf=3'b100, ctl_err=0.
- Load: D_icode=6, D_ifun=1, d_valA=30, d_valB=50, d_dstE=3. Required: one edge later the E outputs match. ALU `cf` for 50−30 (ZF=0, SF=0, OF=0) is latched, so outf=3'b000 after the next edge.
- Flag gating: OPq with ZF result (valA=valB=50, ifun=1) while `m_stat`=STAT_ADR. Required: outf unchanged. With m_stat=W_stat=AOK, outf=3'b100.
- Stall/bubble: load icode 3 (valC=20), then E_stall for 2 cycles with changing D inputs. Required: E holds icode 3 / valC=20. Then E_bubble: E_icode=1, IDs=F.
- Conflict: E_stall=E_bubble=1 for one cycle. Required: E holds and ctl_err=1 exactly one cycle later, then 0.
- Mid-stream reset: OPq in E with set_cc=1 and reset asserted. Required: outf=3'b100 (not `cf`) and E=bubble after the edge.
